// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier unit: op encodings, default
// parameters and helpers that decide operand signedness per op.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    localparam int XLEN_DEFAULT   = 32;
    localparam int STAGES_DEFAULT = 3;
    localparam int TAG_W_DEFAULT  = 5;

    // rs1 is treated as signed for MULH and MULHSU
    function automatic logic a_is_signed(mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    // rs2 is treated as signed only for MULH
    function automatic logic b_is_signed(mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// One pipeline stage: valid bit, sideband tag and data word with hold and
// clear. Clear kills only the valid bit; data and tag are don't-care then.
module mul_pipe_reg
    import mul_pkg::*;
#(
    parameter int TAG_W  = TAG_W_DEFAULT,
    parameter int DATA_W = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              clear,
    input  logic              valid_d,
    input  logic [TAG_W-1:0]  tag_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [TAG_W-1:0]  tag_q,
    output logic [DATA_W-1:0] data_q
);

    // Stage register: clear beats hold, hold beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (!hold) begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/multiplier_unit.sv
// Pipelined RISC-V style multiplier (MUL/MULH/MULHSU/MULHU) with a
// valid/ready interface, global enable, flush and a sideband tag.
// The product is formed in front of stage 1; later stages only carry the
// selected result so they can be retimed into DSP pipeline registers.
module multiplier_unit
    import mul_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int STAGES = STAGES_DEFAULT,
    parameter int TAG_W  = TAG_W_DEFAULT
) (
    input  logic             CLK_0,
    input  logic             RESETN_0,
    input  logic             CE_0,
    input  logic             FLUSH_0,
    input  logic             IN_VALID_0,
    output logic             IN_READY_0,
    input  logic [1:0]       OP_0,
    input  logic [XLEN-1:0]  A_0,
    input  logic [XLEN-1:0]  B_0,
    input  logic [TAG_W-1:0] TAG_0,
    output logic             OUT_VALID_0,
    input  logic             OUT_READY_0,
    output logic [XLEN-1:0]  P_0,
    output logic [TAG_W-1:0] OUT_TAG_0,
    output logic             BUSY_0
);

    // Picks the low word for MUL and the high word for the MULH family
    function automatic logic [XLEN-1:0] select_result(mul_op_e op,
                                                      logic [2*XLEN-1:0] prod);
        return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    mul_op_e                op;
    logic [XLEN:0]          a_ext;
    logic [XLEN:0]          b_ext;
    logic signed [2*XLEN-1:0] a_wide;
    logic signed [2*XLEN-1:0] b_wide;
    logic signed [2*XLEN-1:0] prod;

    logic                   stall;
    logic                   clear;
    logic                   accept;

    // Index 0 is the stage-1 input; index s is the output of stage s.
    logic [STAGES:0]        vld_p;
    logic [TAG_W-1:0]       tag_p [STAGES+1];
    logic [XLEN-1:0]        res_p [STAGES+1];

    // Operand extension to XLEN+1 bits, then the multiply. Bits of the full
    // 2*XLEN+2 product above 2*XLEN are never selected, so the product is
    // formed modulo 2^(2*XLEN), which keeps the selected bits exact.
    always_comb begin
        op     = mul_op_e'(OP_0);
        a_ext  = {a_is_signed(op) & A_0[XLEN-1], A_0};
        b_ext  = {b_is_signed(op) & B_0[XLEN-1], B_0};
        a_wide = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
        b_wide = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
        prod   = a_wide * b_wide;
    end

    // Handshake and pipeline control; ready is forced low while in reset
    always_comb begin
        stall      = (vld_p[STAGES] & ~OUT_READY_0) | ~CE_0;
        clear      = CE_0 & FLUSH_0;
        IN_READY_0 = RESETN_0 & CE_0 & ~stall & ~FLUSH_0;
        accept     = IN_VALID_0 & IN_READY_0;
    end

    assign vld_p[0] = accept;
    assign tag_p[0] = TAG_0;
    assign res_p[0] = select_result(op, prod);

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        mul_pipe_reg #(
            .TAG_W  (TAG_W),
            .DATA_W (XLEN)
        ) u_stage (
            .clk     (CLK_0),
            .rst_n   (RESETN_0),
            .hold    (stall),
            .clear   (clear),
            .valid_d (vld_p[s-1]),
            .tag_d   (tag_p[s-1]),
            .data_d  (res_p[s-1]),
            .valid_q (vld_p[s]),
            .tag_q   (tag_p[s]),
            .data_q  (res_p[s])
        );
    end

    assign OUT_VALID_0 = vld_p[STAGES];
    assign P_0         = res_p[STAGES];
    assign OUT_TAG_0   = tag_p[STAGES];
    assign BUSY_0      = |vld_p[STAGES:1];

endmodule
